// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end feeding the IF/ID pipeline register
//
// Owns the PC and fetches instructions over a level req/ack handshake. It honours
// hazard stalls through a one-entry skid register, and it honours branch/jump redirects.
// A redirect that arrives while a request is outstanding is drained first, so imem_addr
// never changes under an unacknowledged request.
//
// Parameter: RESET_PC - PC loaded on reset (bits [1:0] forced to 0)
// Optional:  FETCH_PERF_CNT_EN - adds fetch_stall_cnt, a saturating count of FETCH wait
//            cycles plus HOLD cycles with stall_in=1
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   stall_in          hold IF/ID and PC this cycle
//   redirect_en/pc    taken branch/jump; load redirect_pc, squash in-flight fetch
//   imem_req/addr     memory request (level) and its address
//   imem_ack/rdata    memory response and its data (same cycle)
//   inst_out/pc_out   instruction and PC+4 presented to IF/ID
//   if_id_write       IF/ID load enable
//   if_id_flush       IF/ID loads a NOP this edge
//   fetch_stall_cnt   (FETCH_PERF_CNT_EN only) stall/wait cycle counter

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        if_id_write,
    output logic        if_id_flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] skid_inst, skid_inst_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] redirect_target;

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= {RESET_PC[31:2], 2'b00};
            req_addr  <= 32'h0;
            skid_inst <= 32'h0;
            skid_pc   <= 32'h0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            skid_inst <= skid_inst_n;
            skid_pc   <= skid_pc_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_addr_n  = req_addr;
        skid_inst_n = skid_inst;
        skid_pc_n   = skid_pc;
        imem_req    = 1'b0;
        imem_addr   = 32'h0;
        inst_out    = 32'h0;
        pc_out      = 32'h0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;

        case (state)
            IDLE: begin
                state_n    = FETCH;
                req_addr_n = pc;
            end

            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                inst_out  = imem_rdata;
                pc_out    = req_addr + 32'd4;
                if (redirect_en) begin
                    if_id_flush = 1'b1;
                    pc_n        = redirect_target;
                    if (imem_ack) begin
                        req_addr_n = redirect_target;
                    end else begin
                        // Request still outstanding: keep req_addr until the ack drains it.
                        state_n = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall_in) begin
                        skid_inst_n = imem_rdata;
                        skid_pc_n   = req_addr;
                        state_n     = HOLD;
                    end else begin
                        if_id_write = 1'b1;
                        pc_n        = req_addr + 32'd4;
                        req_addr_n  = req_addr + 32'd4;
                    end
                end
            end

            HOLD: begin
                inst_out = skid_inst;
                pc_out   = skid_pc + 32'd4;
                if (redirect_en) begin
                    if_id_flush = 1'b1;
                    pc_n        = redirect_target;
                    req_addr_n  = redirect_target;
                    state_n     = FETCH;
                end else if (!stall_in) begin
                    if_id_write = 1'b1;
                    pc_n        = skid_pc + 32'd4;
                    req_addr_n  = skid_pc + 32'd4;
                    state_n     = FETCH;
                end
            end

            DRAIN: begin
                // Old request completes at its original address; its data is dropped.
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (redirect_en) begin
                    if_id_flush = 1'b1;
                    pc_n        = redirect_target;
                end
                if (imem_ack) begin
                    req_addr_n = redirect_en ? redirect_target : pc;
                    state_n    = FETCH;
                end
            end

            default: state_n = IDLE;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic count_cycle;

    assign count_cycle = ((state == FETCH) && !imem_ack) || ((state == HOLD) && stall_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_stall_cnt <= 32'h0;
        end else if (count_cycle && (fetch_stall_cnt != 32'hFFFF_FFFF)) begin
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        if_id_write;
    logic        if_id_flush;

    logic        w_stall = 1'b0;
    logic        w_redir = 1'b0;
    logic [31:0] w_redir_pc = 32'h0;
    logic        w_ack = 1'b1;
    logic [31:0] w_rdata;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_inst;
    logic [31:0] w_pc_out;
    logic        w_write;
    logic        w_flush;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
    logic [31:0] w_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    assign imem_rdata = imem_addr ^ SALT;
    assign w_rdata    = w_addr ^ SALT;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
        .pc_out(pc_out), .if_id_write(if_id_write), .if_id_flush(if_id_flush)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_stall_cnt(fetch_stall_cnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall_in(w_stall), .redirect_en(w_redir),
        .redirect_pc(w_redir_pc), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_out(w_inst),
        .pc_out(w_pc_out), .if_id_write(w_write), .if_id_flush(w_flush)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_stall_cnt(w_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-order model: IF/ID must receive consecutive words starting at the reset PC,
    // restarting at each redirect target; every word carries the memory content at its PC.
    logic [31:0] exp_pc;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        if (!rst) begin
            exp_pc   = 32'h0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
            prev_addr = 32'h0;
        end else begin
            check("mdl_write_flush_exclusive", {31'b0, if_id_write & if_id_flush}, 32'h0);
            if (prev_req && !prev_ack && imem_req)
                check("mdl_addr_stable", imem_addr, prev_addr);
            if (if_id_flush)
                check("mdl_flush_needs_redirect", {31'b0, redirect_en}, 32'h1);
            if (redirect_en) begin
                check("mdl_no_write_on_redirect", {31'b0, if_id_write}, 32'h0);
                exp_pc = redirect_pc;
            end else if (if_id_write) begin
                check("mdl_pc_out", pc_out, exp_pc + 32'd4);
                check("mdl_inst_out", inst_out, exp_pc ^ SALT);
                exp_pc = exp_pc + 32'd4;
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic cyc(input logic ack, input logic stall, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        imem_ack    = ack;
        stall_in    = stall;
        redirect_en = redir;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_write", {31'b0, if_id_write}, 32'h0);
        check("rst_flush", {31'b0, if_id_flush}, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_inst", inst_out, 32'h0);

        // C0: reset released, unit idles one cycle
        @(posedge clk);
        #1;
        rst = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        check("c0_req", {31'b0, imem_req}, 32'h0);
        check("c0_write", {31'b0, if_id_write}, 32'h0);

        cyc(1, 0, 0, 0);                                // C1
        check("c1_addr", imem_addr, 32'h0);
        check("c1_write", {31'b0, if_id_write}, 32'h1);
        check("c1_pc_out", pc_out, 32'h4);
        check("c1_inst", inst_out, 32'hA5A5_0000);
        check("wrap_addr", w_addr, 32'hFFFF_FFFC);
        check("wrap_pc_out", w_pc_out, 32'h0);
        check("wrap_write", {31'b0, w_write}, 32'h1);

        cyc(1, 0, 0, 0);                                // C2
        check("c2_addr", imem_addr, 32'h4);
        check("c2_pc_out", pc_out, 32'h8);
        check("wrap_next_addr", w_addr, 32'h0);

        cyc(1, 1, 0, 0);                                // C3: ack of 8 while stalled
        check("c3_addr", imem_addr, 32'h8);
        check("c3_write", {31'b0, if_id_write}, 32'h0);

        for (int i = 0; i < 3; i++) begin               // C4..C6: HOLD under stall
            cyc(1, 1, 0, 0);
            check("hold_req", {31'b0, imem_req}, 32'h0);
            check("hold_write", {31'b0, if_id_write}, 32'h0);
            check("hold_inst", inst_out, 32'hA5A5_0008);
            check("hold_pc_out", pc_out, 32'hC);
        end

        cyc(1, 0, 0, 0);                                // C7: stall released
        check("unhold_write", {31'b0, if_id_write}, 32'h1);
        check("unhold_pc_out", pc_out, 32'hC);

        cyc(1, 0, 0, 0);                                // C8
        check("after_hold_addr", imem_addr, 32'hC);

        cyc(0, 0, 1, 32'h100);                          // C9: redirect, 0x10 outstanding
        check("redir_addr", imem_addr, 32'h10);
        check("redir_flush", {31'b0, if_id_flush}, 32'h1);
        check("redir_write", {31'b0, if_id_write}, 32'h0);

        cyc(0, 0, 0, 0);                                // C10: draining
        check("drain_req", {31'b0, imem_req}, 32'h1);
        check("drain_addr", imem_addr, 32'h10);
        check("drain_flush", {31'b0, if_id_flush}, 32'h0);

        cyc(1, 0, 0, 0);                                // C11: late ack dropped
        check("drain_ack_addr", imem_addr, 32'h10);
        check("drain_ack_write", {31'b0, if_id_write}, 32'h0);

        cyc(0, 0, 0, 0);                                // C12: wait state at target
        check("target_addr", imem_addr, 32'h100);

        cyc(1, 0, 0, 0);                                // C13
        check("target_write", {31'b0, if_id_write}, 32'h1);
        check("target_pc_out", pc_out, 32'h104);

        cyc(1, 1, 0, 0);                                // C14: stall into HOLD
        check("c14_addr", imem_addr, 32'h104);
`ifdef FETCH_PERF_CNT_EN
        check("perf_cnt", fetch_stall_cnt, 32'd5);
`endif

        cyc(1, 1, 1, 32'h200);                          // C15: redirect + stall in HOLD
        check("hold_redir_flush", {31'b0, if_id_flush}, 32'h1);
        check("hold_redir_write", {31'b0, if_id_write}, 32'h0);

        cyc(1, 0, 0, 0);                                // C16
        check("hold_redir_addr", imem_addr, 32'h200);
        check("hold_redir_pc_out", pc_out, 32'h204);

        @(posedge clk);                                 // C17: request outstanding, then reset
        #1;
        imem_ack = 1'b0;
        #1;
        check("mid_req", {31'b0, imem_req}, 32'h1);
        check("mid_addr", imem_addr, 32'h204);
        rst = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'h0);
        check("async_addr", imem_addr, 32'h0);
        check("async_pc_out", pc_out, 32'h0);
        check("async_inst", inst_out, 32'h0);
        check("async_wrap_req", {31'b0, w_req}, 32'h0);

        cyc(1, 0, 0, 0);                                // ack while held in reset
        check("rst_ack_write", {31'b0, if_id_write}, 32'h0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("idle_late_ack_req", {31'b0, imem_req}, 32'h0);
        check("idle_late_ack_write", {31'b0, if_id_write}, 32'h0);

        cyc(1, 0, 0, 0);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_pc_out", pc_out, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
